// File: rtl/can_fault_confinement.sv
// CAN fault confinement: maintains the transmit and receive error counters,
// derives the node error state (active / passive / bus-off) from them, and
// runs the bus-off recovery sequence of 128 runs of 11 recessive bits.
module can_fault_confinement #(
    parameter int unsigned WARNING_LIMIT = 96,
    parameter int unsigned REC_RELOAD    = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       sample_point,
    input  logic       rx_bit,
    input  logic       transmitting,
    input  logic       bit_error,
    input  logic       stuff_error,
    input  logic       crc_error,
    input  logic       form_error,
    input  logic       ack_error,
    input  logic       tx_success,
    input  logic       rx_success,
    output logic [8:0] tec,
    output logic [7:0] rec,
    output logic [1:0] error_state,
    output logic       is_passive_error_flag,
    output logic       bus_off,
    output logic       error_warning
);

    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'b00,
        ST_PASSIVE = 2'b01,
        ST_BUS_OFF = 2'b10
    } state_t;

    localparam logic [8:0] WARN_TEC     = 9'(WARNING_LIMIT);
    localparam logic [7:0] WARN_REC     = 8'(WARNING_LIMIT);
    localparam logic [7:0] REC_RELOAD_V = 8'(REC_RELOAD);
    localparam logic [3:0] RUN_LAST     = 4'd10;   // 11th recessive bit completes a run
    localparam logic [7:0] OCC_DONE     = 8'd128;

    state_t     state_q;
    state_t     state_d;
    logic       sample_q;
    logic [3:0] run_q;
    logic [3:0] run_d;
    logic [7:0] occ_q;
    logic [7:0] occ_d;
    logic [8:0] tec_d;
    logic [7:0] rec_d;
    logic       any_error;
    logic       ack_only;
    logic       error_event;

    assign any_error   = bit_error | stuff_error | crc_error | form_error | ack_error;
    assign ack_only    = ack_error & ~(bit_error | stuff_error | crc_error | form_error);
    // Flags belong to the bit sampled on the previous cycle, hence sample_q.
    assign error_event = enable & sample_q & any_error & (state_q != ST_BUS_OFF);
    assign error_state = state_q;

    // Next-state computation for counters, recovery counters and error state.
    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        tec_d   = tec;
        rec_d   = rec;
        run_d   = run_q;
        occ_d   = occ_q;
        state_d = state_q;

        if (state_q == ST_BUS_OFF) begin
            // Errors and success strobes are ignored; only recovery progresses.
            if (enable && sample_point) begin
                if (!rx_bit) begin
                    run_d = 4'd0;               // dominant bit drops the partial run only
                end else if (run_q == RUN_LAST) begin
                    run_d = 4'd0;
                    occ_d = occ_q + 8'd1;
                end else begin
                    run_d = run_q + 4'd1;
                end
            end
            if (occ_d == OCC_DONE) begin
                tec_d = 9'd0;
                rec_d = 8'd0;
                run_d = 4'd0;
                occ_d = 8'd0;
            end
        end else if (enable) begin
            if (error_event) begin
                // An error in the same cycle as a success strobe wins outright.
                if (transmitting) begin
                    if (!(ack_only && state_q == ST_PASSIVE)) begin
                        tec_d = tec + 9'd8;
                    end
                end else if (rec != 8'hFF) begin
                    rec_d = rec + 8'd1;
                end
            end else begin
                if (tx_success && tec != 9'd0) begin
                    tec_d = tec - 9'd1;
                end
                if (rx_success) begin
                    if (rec > 8'd127) begin
                        rec_d = REC_RELOAD_V;
                    end else if (rec != 8'd0) begin
                        rec_d = rec - 8'd1;
                    end
                end
            end
            if (tec_d > 9'd255) begin
                tec_d = 9'd256;                 // clamp on bus-off entry
            end
        end

        // State always follows the counter values that will be registered.
        if (tec_d > 9'd255) begin
            state_d = ST_BUS_OFF;
        end else if (tec_d > 9'd127 || rec_d > 8'd127) begin
            state_d = ST_PASSIVE;
        end else begin
            state_d = ST_ACTIVE;
        end
    end

    // Register counters, state and all outputs; reset overrides enable.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            sample_q              <= 1'b0;
            tec                   <= 9'd0;
            rec                   <= 8'd0;
            run_q                 <= 4'd0;
            occ_q                 <= 8'd0;
            state_q               <= ST_ACTIVE;
            is_passive_error_flag <= 1'b0;
            bus_off               <= 1'b0;
            error_warning         <= 1'b0;
        end else if (enable) begin
            sample_q              <= sample_point;
            tec                   <= tec_d;
            rec                   <= rec_d;
            run_q                 <= run_d;
            occ_q                 <= occ_d;
            state_q               <= state_d;
            is_passive_error_flag <= (state_d == ST_PASSIVE);
            bus_off               <= (state_d == ST_BUS_OFF);
            error_warning         <= (tec_d >= WARN_TEC) || (rec_d >= WARN_REC);
        end
    end

endmodule

// File: tb/tb_can_fault_confinement.sv
// Directed self-checking bench for can_fault_confinement.
module tb_can_fault_confinement;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       sample_point;
    logic       rx_bit;
    logic       transmitting;
    logic       bit_error;
    logic       stuff_error;
    logic       crc_error;
    logic       form_error;
    logic       ack_error;
    logic       tx_success;
    logic       rx_success;
    logic [8:0] tec;
    logic [7:0] rec;
    logic [1:0] error_state;
    logic       is_passive_error_flag;
    logic       bus_off;
    logic       error_warning;

    int pass_cnt  = 0;
    int total_cnt = 0;

    can_fault_confinement dut (
        .clock                 (clock),
        .reset                 (reset),
        .enable                (enable),
        .sample_point          (sample_point),
        .rx_bit                (rx_bit),
        .transmitting          (transmitting),
        .bit_error             (bit_error),
        .stuff_error           (stuff_error),
        .crc_error             (crc_error),
        .form_error            (form_error),
        .ack_error             (ack_error),
        .tx_success            (tx_success),
        .rx_success            (rx_success),
        .tec                   (tec),
        .rec                   (rec),
        .error_state           (error_state),
        .is_passive_error_flag (is_passive_error_flag),
        .bus_off               (bus_off),
        .error_warning         (error_warning)
    );

    always #5 clock = ~clock;

    // Advance one edge and settle 1 time unit past it before touching anything.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        enable       = 1'b1;
        sample_point = 1'b0;
        rx_bit       = 1'b0;
        transmitting = 1'b0;
        bit_error    = 1'b0;
        stuff_error  = 1'b0;
        crc_error    = 1'b0;
        form_error   = 1'b0;
        ack_error    = 1'b0;
        tx_success   = 1'b0;
        rx_success   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        idle_inputs();
        reset = 1'b0;
    endtask

    // Sample point, then flags {bit,stuff,crc,form,ack} on the following cycle.
    task automatic err_event(input logic tx, input logic [4:0] flags, input logic rxs);
        sample_point = 1'b1;
        tick();
        sample_point = 1'b0;
        transmitting = tx;
        {bit_error, stuff_error, crc_error, form_error, ack_error} = flags;
        rx_success   = rxs;
        tick();
        {bit_error, stuff_error, crc_error, form_error, ack_error} = 5'b0;
        rx_success   = 1'b0;
    endtask

    task automatic bus_bit(input logic b);
        sample_point = 1'b1;
        rx_bit       = b;
        tick();
        sample_point = 1'b0;
        rx_bit       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            {enable, sample_point, rx_bit, transmitting, bit_error, stuff_error} = 6'($urandom);
            {crc_error, form_error, ack_error, tx_success, rx_success} = 5'($urandom);
            tick();
        end
        idle_inputs();
        reset = 1'b0;
        total_cnt++;
        if (tec !== 9'd0) $display("FAIL reset_tec: got %0d expected 0", tec);
        else pass_cnt++;
        total_cnt++;
        if (rec !== 8'd0) $display("FAIL reset_rec: got %0d expected 0", rec);
        else pass_cnt++;
        total_cnt++;
        if (error_state !== 2'b00) $display("FAIL reset_state: got %b expected 00", error_state);
        else pass_cnt++;
        total_cnt++;
        if ({is_passive_error_flag, bus_off, error_warning} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {is_passive_error_flag, bus_off, error_warning});
        else pass_cnt++;
    endtask

    task automatic test_tec_growth();
        do_reset();
        for (int i = 0; i < 12; i++) err_event(1'b1, 5'b10000, 1'b0);
        total_cnt++;
        if (tec !== 9'd96) $display("FAIL tec_growth_96: got %0d expected 96", tec);
        else pass_cnt++;
        total_cnt++;
        if ({error_warning, error_state} !== 3'b100)
            $display("FAIL tec_growth_warning: got warn/state %b expected 100", {error_warning, error_state});
        else pass_cnt++;
        for (int i = 0; i < 4; i++) err_event(1'b1, 5'b10000, 1'b0);
        total_cnt++;
        if (tec !== 9'd128) $display("FAIL tec_growth_128: got %0d expected 128", tec);
        else pass_cnt++;
        total_cnt++;
        if ({is_passive_error_flag, error_state} !== 3'b101)
            $display("FAIL tec_growth_passive: got flag/state %b expected 101", {is_passive_error_flag, error_state});
        else pass_cnt++;
    endtask

    task automatic test_passive_ack();
        err_event(1'b1, 5'b00001, 1'b0);
        total_cnt++;
        if (tec !== 9'd128) $display("FAIL passive_ack_only: got %0d expected 128", tec);
        else pass_cnt++;
        err_event(1'b1, 5'b00011, 1'b0);
        total_cnt++;
        if (tec !== 9'd136) $display("FAIL passive_ack_form: got %0d expected 136", tec);
        else pass_cnt++;
    endtask

    task automatic test_enable_hold();
        enable = 1'b0;
        err_event(1'b1, 5'b10000, 1'b0);
        tx_success = 1'b1;
        tick();
        tx_success = 1'b0;
        enable = 1'b1;
        total_cnt++;
        if (tec !== 9'd136) $display("FAIL enable_hold: got %0d expected 136", tec);
        else pass_cnt++;
    endtask

    task automatic test_success();
        do_reset();
        err_event(1'b1, 5'b01000, 1'b0);
        tx_success = 1'b1;
        tick();
        tx_success = 1'b0;
        total_cnt++;
        if (tec !== 9'd7) $display("FAIL tx_success_dec: got %0d expected 7", tec);
        else pass_cnt++;
        rx_success = 1'b1;
        tick();
        rx_success = 1'b0;
        total_cnt++;
        if (rec !== 8'd0) $display("FAIL rx_success_zero: got %0d expected 0", rec);
        else pass_cnt++;
    endtask

    task automatic test_bus_off();
        do_reset();
        for (int i = 0; i < 31; i++) err_event(1'b1, 5'b00100, 1'b0);
        total_cnt++;
        if ({tec, error_state} !== {9'd248, 2'b01})
            $display("FAIL bus_off_pre: got tec %0d state %b expected 248 01", tec, error_state);
        else pass_cnt++;
        err_event(1'b1, 5'b00100, 1'b0);
        total_cnt++;
        if (tec !== 9'd256) $display("FAIL bus_off_tec: got %0d expected 256", tec);
        else pass_cnt++;
        total_cnt++;
        if ({bus_off, is_passive_error_flag, error_state} !== 4'b1010)
            $display("FAIL bus_off_state: got %b expected 1010", {bus_off, is_passive_error_flag, error_state});
        else pass_cnt++;
        err_event(1'b1, 5'b10000, 1'b0);
        err_event(1'b0, 5'b10000, 1'b0);
        tx_success = 1'b1;
        tick();
        tx_success = 1'b0;
        total_cnt++;
        if ({tec, rec} !== {9'd256, 8'd0})
            $display("FAIL bus_off_ignore: got tec %0d rec %0d expected 256 0", tec, rec);
        else pass_cnt++;
    endtask

    task automatic test_recovery();
        for (int i = 0; i < 10; i++) bus_bit(1'b1);
        bus_bit(1'b0);
        for (int i = 0; i < 128 * 11 - 1; i++) bus_bit(1'b1);
        total_cnt++;
        if ({bus_off, error_state, tec} !== {1'b1, 2'b10, 9'd256})
            $display("FAIL recovery_early: got bus_off %b state %b tec %0d expected 1 10 256", bus_off, error_state, tec);
        else pass_cnt++;
        bus_bit(1'b1);
        total_cnt++;
        if ({error_state, tec, rec} !== {2'b00, 9'd0, 8'd0})
            $display("FAIL recovery_done: got state %b tec %0d rec %0d expected 00 0 0", error_state, tec, rec);
        else pass_cnt++;
        total_cnt++;
        if ({bus_off, error_warning} !== 2'b00)
            $display("FAIL recovery_flags: got %b expected 00", {bus_off, error_warning});
        else pass_cnt++;
    endtask

    task automatic test_rec_rules();
        do_reset();
        for (int i = 0; i < 130; i++) err_event(1'b0, 5'b00010, 1'b0);
        total_cnt++;
        if ({rec, error_state} !== {8'd130, 2'b01})
            $display("FAIL rec_130: got rec %0d state %b expected 130 01", rec, error_state);
        else pass_cnt++;
        rx_success = 1'b1;
        tick();
        rx_success = 1'b0;
        total_cnt++;
        if ({rec, error_state, error_warning} !== {8'd120, 2'b00, 1'b1})
            $display("FAIL rec_reload: got rec %0d state %b warn %b expected 120 00 1", rec, error_state, error_warning);
        else pass_cnt++;
        err_event(1'b0, 5'b10000, 1'b1);
        total_cnt++;
        if (rec !== 8'd121) $display("FAIL rec_err_priority: got %0d expected 121", rec);
        else pass_cnt++;
        for (int i = 0; i < 135; i++) err_event(1'b0, 5'b01000, 1'b0);
        total_cnt++;
        if ({rec, tec} !== {8'd255, 9'd0})
            $display("FAIL rec_saturate: got rec %0d tec %0d expected 255 0", rec, tec);
        else pass_cnt++;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_tec_growth();
        test_passive_ack();
        test_enable_hold();
        test_success();
        test_bus_off();
        test_recovery();
        test_rec_rules();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
